dsp_int8_packing: RTL and testbench

DSP_INT8_PACKING -- requirements
Module: dsp_int8_packing

---
 rtl/dsp_int8_packing.sv | 85 ++++++++
 tb/tb_dsp_int8_packing.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dsp_int8_packing.sv
// Two INT8 products (a*c, b*c) sharing one wide multiply by packing a and b into one operand.
// Fixed 3-stage pipeline: input regs, wide product reg, unpacked result regs.
module dsp_int8_packing #(
  parameter int unsigned PACK_SHIFT = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic        [7:0]  a,
  input  logic        [7:0]  b,
  input  logic signed [7:0]  c,
  output logic signed [32:0] p,
  output logic signed [15:0] ac,
  output logic signed [15:0] bc
);

  localparam int unsigned PKW = PACK_SHIFT + 8;
  localparam int unsigned PW  = PACK_SHIFT + 17;

  logic        [7:0]    r_a;
  logic        [7:0]    r_b;
  logic signed [7:0]    r_c;
  logic signed [PW-1:0] r_prod;

  logic        [PKW-1:0] w_packed;
  logic signed [PW-1:0]  w_a_ext;
  logic signed [PW-1:0]  w_c_ext;
  logic signed [PW-1:0]  w_prod;
  logic signed [15:0]    w_ac;
  logic signed [15:0]    w_bc;
  logic signed [32:0]    w_p;
  logic                  w_unused;

  // Stage 1: capture operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= 8'd0;
      r_b <= 8'd0;
      r_c <= 8'sd0;
    end else begin
      r_a <= a;
      r_b <= b;
      r_c <= c;
    end
  end

  // Packed operand is non-negative; the extra zero MSB keeps it positive in signed arithmetic
  always_comb begin
    w_packed = (PKW'(r_a) << PACK_SHIFT) | PKW'(r_b);
    w_a_ext  = PW'({1'b0, w_packed});
    w_c_ext  = PW'(r_c);
    w_prod   = w_a_ext * w_c_ext;
  end

  // Stage 2: wide product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
    end else begin
      r_prod <= w_prod;
    end
  end

  // A negative b*c borrows one from the a*c field; its sign bit sits at PACK_SHIFT-1
  always_comb begin
    w_bc = r_prod[15:0];
    w_ac = r_prod[PACK_SHIFT+15 -: 16] + 16'(r_prod[PACK_SHIFT-1]);
    w_p  = (33'(w_ac) <<< 8) + 33'(w_bc);
  end

  assign w_unused = ^{r_prod[PW-1:PACK_SHIFT+16], r_prod[PACK_SHIFT-2:16]};

  // Stage 3: unpacked results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac <= 16'sd0;
      bc <= 16'sd0;
      p  <= 33'sd0;
    end else begin
      ac <= w_ac;
      bc <= w_bc;
      p  <= w_p;
    end
  end

endmodule

// File: tb/tb_dsp_int8_packing.sv
// Randomized bench for dsp_int8_packing: reference products from plain integer math, 3-cycle delayed.
module tb_dsp_int8_packing;

  typedef struct {
    int ac;
    int bc;
    int p;
  } res_t;

  logic               clk;
  logic               rst_n;
  logic        [7:0]  a;
  logic        [7:0]  b;
  logic signed [7:0]  c;
  logic signed [32:0] p;
  logic signed [15:0] ac;
  logic signed [15:0] bc;

  int   checks;
  int   errors;
  bit   cmp_en;
  res_t cur;
  res_t q[$];

  dsp_int8_packing #(.PACK_SHIFT(18)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .p    (p),
    .ac   (ac),
    .bc   (bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_of(input logic [7:0] ia, input logic [7:0] ib, input logic signed [7:0] ic);
    res_t r;
    int   va;
    int   vb;
    int   vc;
    va   = int'(ia);
    vb   = int'(ib);
    vc   = int'(ic);
    r.ac = va * vc;
    r.bc = vb * vc;
    r.p  = r.ac * 256 + r.bc;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pipeline: what was sampled at edge N is the expectation after edge N+2
  initial begin
    res_t z;
    z = '{0, 0, 0};
    cur = z;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        q.push_back(z);
        q.push_back(z);
        cur = z;
      end else begin
        q.push_back(ref_of(a, b, c));
        cur = q.pop_front();
      end
    end
  end

  // Every-cycle comparison against the reference
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("stream_ac", int'(ac), cur.ac);
        chk("stream_bc", int'(bc), cur.bc);
        chk("stream_p",  int'(p),  cur.p);
      end
    end
  end

  task automatic directed(input logic [7:0] ia, input logic [7:0] ib, input logic signed [7:0] ic,
                          input int eac, input int ebc, input int ep, input string name);
    @(negedge clk);
    a = ia;
    b = ib;
    c = ic;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_ac"}, int'(ac), eac);
    chk({name, "_bc"}, int'(bc), ebc);
    chk({name, "_p"},  int'(p),  ep);
    chk({name, "_model_p"}, cur.p, ep);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0:       begin a = 8'd255; b = 8'd255; c = -8'sd128; end
        1:       begin a = 8'd0;   b = 8'($urandom); c = 8'($urandom); end
        default: begin a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); end
      endcase
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    a = 8'd0;
    b = 8'd0;
    c = 8'sd0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;

    // Outputs stay cleared under reset even with activity on the inputs
    @(negedge clk);
    a = 8'd200; b = 8'd100; c = -8'sd7;
    repeat (2) @(negedge clk);
    chk("reset_ac", int'(ac), 0);
    chk("reset_bc", int'(bc), 0);
    chk("reset_p",  int'(p),  0);
    rst_n = 1'b1;

    directed(8'd10,  8'd5,   -8'sd3,   -30,    -15,    -7695,    "d_10_5_m3");
    directed(8'd12,  8'd4,   -8'sd2,   -24,    -8,     -6152,    "d_12_4_m2");
    directed(8'd1,   8'd1,   -8'sd1,   -1,     -1,     -257,     "d_1_1_m1");
    directed(8'd50,  8'd20,  -8'sd1,   -50,    -20,    -12820,   "d_50_20_m1");
    directed(8'd17,  8'd98,  -8'sd63,  -1071,  -6174,  -280350,  "d_17_98_m63");
    directed(8'd255, 8'd255, -8'sd128, -32640, -32640, -8388480, "d_max_neg");
    directed(8'd255, 8'd255, 8'sd127,  32385,  32385,  8322945,  "d_max_pos");
    directed(8'd0,   8'd255, -8'sd1,   0,      -255,   -255,     "d_borrow");

    rand_cycles(300);

    // Asynchronous reset mid-stream, asserted between clock edges
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ac", int'(ac), 0);
    chk("async_rst_bc", int'(bc), 0);
    chk("async_rst_p",  int'(p),  0);
    rand_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'd3; b = 8'd7; c = -8'sd5;
    @(negedge clk);
    chk("post_rst_stale_p", int'(p), 0);
    rand_cycles(300);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
